// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - 8b/10b encoder constants and coding tables
package enc8b10b_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  function automatic logic isLegalK(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
           (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Returns {abcdei at RD-, complement-at-RD+ flag}.
  function automatic logic [6:0] table5b6b(input logic [4:0] x, input logic k);
    logic [5:0] code;
    code = 6'b000000;
    case (x)
      5'd0:  code = 6'b100111;
      5'd1:  code = 6'b011101;
      5'd2:  code = 6'b101101;
      5'd3:  code = 6'b110001;
      5'd4:  code = 6'b110101;
      5'd5:  code = 6'b101001;
      5'd6:  code = 6'b011001;
      5'd7:  code = 6'b111000;
      5'd8:  code = 6'b111001;
      5'd9:  code = 6'b100101;
      5'd10: code = 6'b010101;
      5'd11: code = 6'b110100;
      5'd12: code = 6'b001101;
      5'd13: code = 6'b101100;
      5'd14: code = 6'b011100;
      5'd15: code = 6'b010111;
      5'd16: code = 6'b011011;
      5'd17: code = 6'b100011;
      5'd18: code = 6'b010011;
      5'd19: code = 6'b110010;
      5'd20: code = 6'b001011;
      5'd21: code = 6'b101010;
      5'd22: code = 6'b011010;
      5'd23: code = 6'b111010;
      5'd24: code = 6'b110011;
      5'd25: code = 6'b100110;
      5'd26: code = 6'b010110;
      5'd27: code = 6'b110110;
      5'd28: code = k ? 6'b001111 : 6'b001110;
      5'd29: code = 6'b101110;
      5'd30: code = 6'b011110;
      5'd31: code = 6'b101011;
      default: code = 6'b000000;
    endcase
    return {code, ($countones(code) != 3) || (x == 5'd7)};
  endfunction

  // Returns {fghj at RD-, complement-at-RD+ flag}; .7 is the primary P7 code.
  function automatic logic [4:0] table3b4b(input logic [2:0] y);
    logic [4:0] ent;
    ent = 5'b00000;
    case (y)
      3'd0: ent = {4'b1011, 1'b1};
      3'd1: ent = {4'b1001, 1'b0};
      3'd2: ent = {4'b0101, 1'b0};
      3'd3: ent = {4'b1100, 1'b1};
      3'd4: ent = {4'b1101, 1'b1};
      3'd5: ent = {4'b1010, 1'b0};
      3'd6: ent = {4'b0110, 1'b0};
      3'd7: ent = {4'b1110, 1'b1};
      default: ent = 5'b00000;
    endcase
    return ent;
  endfunction

endpackage

// File: rtl/enc_5b6b.sv
// rtl/enc_5b6b.sv - 5b/6b sub-block encoder with mid-symbol running disparity
module enc_5b6b
  import enc8b10b_pkg::*;
(
  input  logic [4:0] edcba,
  input  logic       isK,
  input  logic       rdIn,
  output logic [5:0] abcdei,
  output logic       rdMid
);

  logic [6:0] ent;

  always_comb begin
    ent    = table5b6b(edcba, isK);
    abcdei = (ent[0] && rdIn) ? ~ent[6:1] : ent[6:1];
    // D.7 is balanced in both polarities, so it leaves RD untouched here too.
    if ($countones(abcdei) == 3) rdMid = rdIn;
    else                         rdMid = ($countones(abcdei) > 3);
  end

endmodule

// File: rtl/encoder.sv
// rtl/encoder.sv - 8b/10b TX line encoder with running disparity and idle fill
module encoder
  import enc8b10b_pkg::*;
#(
  parameter logic INIT_RD = 1'b0
) (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic [7:0] TxParallel_8,
  input  logic       TxDataK,
  input  logic       TxDataValid,
  output logic [9:0] TxParallel_10,
  output logic       RunningDisp,
  output logic       CodeErr
);

  logic       rdReg;
  logic [7:0] encByte;
  logic       encK;
  logic       codeErrNext;
  logic [5:0] abcdei;
  logic       rdMid;
  logic [4:0] ent4;
  logic       useA7;
  logic [3:0] fghj;
  logic       rdNext;

  always_comb begin
    codeErrNext = TxDataValid && TxDataK && !isLegalK(TxParallel_8);
    encByte     = TxParallel_8;
    encK        = TxDataK;
    if (!TxDataValid || codeErrNext) begin
      encByte = K28_5;
      encK    = 1'b1;
    end
  end

  enc_5b6b u5b6b (
    .edcba  (encByte[4:0]),
    .isK    (encK),
    .rdIn   (rdReg),
    .abcdei (abcdei),
    .rdMid  (rdMid)
  );

  always_comb begin
    ent4  = table3b4b(encByte[7:5]);
    useA7 = (encByte[7:5] == 3'd7) &&
            (encK ||
             (!rdMid && (encByte[4:0] == 5'd17 || encByte[4:0] == 5'd18 ||
                         encByte[4:0] == 5'd20)) ||
             ( rdMid && (encByte[4:0] == 5'd11 || encByte[4:0] == 5'd13 ||
                         encByte[4:0] == 5'd14)));
    if (useA7) fghj = rdMid ? 4'b1000 : 4'b0111;
    else       fghj = (ent4[0] && rdMid) ? ~ent4[4:1] : ent4[4:1];
    // K28 balanced tails (.1 .2 .5 .6) invert with RD_mid so the comma bits line up.
    if (encK && encByte[4:0] == 5'd28 && !rdMid && !ent4[0]) fghj = ~fghj;
    if ($countones(fghj) == 2) rdNext = rdMid;
    else                       rdNext = ($countones(fghj) > 2);
  end

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      TxParallel_10 <= 10'h000;
      rdReg         <= INIT_RD;
      CodeErr       <= 1'b0;
    end else begin
      TxParallel_10 <= {abcdei, fghj};
      rdReg         <= rdNext;
      CodeErr       <= codeErrNext;
    end
  end

  assign RunningDisp = rdReg;

endmodule

// File: tb/tb_encoder.sv
// tb/tb_encoder.sv - directed and random self-checking bench for encoder
module tb_encoder;

  logic       BitCLK_10 = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] TxParallel_8 = 8'h00;
  logic       TxDataK = 1'b0;
  logic       TxDataValid = 1'b0;
  logic [9:0] TxParallel_10;
  logic       RunningDisp;
  logic       CodeErr;

  int tests = 0;
  int failed = 0;

  encoder #(.INIT_RD(1'b0)) dut (
    .BitCLK_10     (BitCLK_10),
    .Reset         (Reset),
    .TxParallel_8  (TxParallel_8),
    .TxDataK       (TxDataK),
    .TxDataValid   (TxDataValid),
    .TxParallel_10 (TxParallel_10),
    .RunningDisp   (RunningDisp),
    .CodeErr       (CodeErr)
  );

  always #5 BitCLK_10 = ~BitCLK_10;

  localparam logic [5:0] D6M [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4M [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [7:0] LEGALK [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input logic [9:0] sym, input logic rd, input logic err);
    chk({tag, ".sym"}, TxParallel_10, sym);
    chk({tag, ".rd"}, 10'(RunningDisp), 10'(rd));
    chk({tag, ".err"}, 10'(CodeErr), 10'(err));
  endtask

  task automatic step(input logic [7:0] b, input logic k, input logic v);
    @(negedge BitCLK_10);
    Reset        = 1'b1;
    TxParallel_8 = b;
    TxDataK      = k;
    TxDataValid  = v;
    @(posedge BitCLK_10);
    #1;
  endtask

  task automatic refEnc(input logic [7:0] bIn, input logic kIn, input logic v, input logic rd,
                        output logic [9:0] sym, output logic rdo, output logic err);
    logic [7:0] b;
    logic       k;
    logic       legal;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       mid;
    logic       a7;
    legal = 1'b0;
    for (int i = 0; i < 12; i++) if (bIn == LEGALK[i]) legal = 1'b1;
    err = v && kIn && !legal;
    b = bIn;
    k = kIn;
    if (!v || err) begin
      b = 8'hBC;
      k = 1'b1;
    end
    x  = b[4:0];
    y  = b[7:5];
    c6 = (k && x == 5'd28) ? 6'b001111 : D6M[x];
    if (rd && ($countones(c6) > 3 || x == 5'd7)) c6 = ~c6;
    mid = ($countones(c6) == 3) ? rd : ($countones(c6) > 3);
    a7 = (y == 3'd7) && (k || (!mid && (x == 17 || x == 18 || x == 20)) ||
                         (mid && (x == 11 || x == 13 || x == 14)));
    c4 = a7 ? 4'b0111 : D4M[y];
    if (mid && ($countones(c4) > 2 || y == 3'd3)) c4 = ~c4;
    if (k && x == 5'd28 && !mid && (y == 1 || y == 2 || y == 5 || y == 6)) c4 = ~c4;
    rdo = ($countones(c4) == 2) ? mid : ($countones(c4) > 2);
    sym = {c6, c4};
  endtask

  initial begin
    logic [9:0] eSym;
    logic       eRd, eErr, mRd, v, k;
    logic [7:0] b;
    int         rs, disp;

    @(posedge BitCLK_10);
    @(posedge BitCLK_10);
    #1;
    expect3("reset", 10'h000, 1'b0, 1'b0);

    step(8'h55, 1'b1, 1'b0); expect3("idle0", 10'h0FA, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0); expect3("idle1", 10'h305, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0); expect3("idle2", 10'h0FA, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0); expect3("idle3", 10'h305, 1'b0, 1'b0);

    step(8'h00, 1'b0, 1'b1); expect3("d0.0a", 10'h274, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1); expect3("d0.0b", 10'h274, 1'b0, 1'b0);
    step(8'hB5, 1'b0, 1'b1); expect3("d21.5", 10'h2AA, 1'b0, 1'b0);
    step(8'hBC, 1'b1, 1'b1); expect3("k28.5n", 10'h0FA, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b1); expect3("k28.5p", 10'h305, 1'b0, 1'b0);
    step(8'hF1, 1'b0, 1'b1); expect3("d17.7a7", 10'h237, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0); expect3("idle4", 10'h305, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1); expect3("badk", 10'h0FA, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1); expect3("d0.0p", 10'h18B, 1'b1, 1'b0);
    step(8'hFC, 1'b1, 1'b1); expect3("k28.7p", 10'h307, 1'b1, 1'b0);
    step(8'hF7, 1'b1, 1'b1); expect3("k23.7p", 10'h057, 1'b1, 1'b0);
    step(8'hEB, 1'b0, 1'b1); expect3("d11.7a7", 10'h348, 1'b0, 1'b0);

    mRd = 1'b0;
    rs  = -1;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0 || $urandom_range(99) == 0) begin
        #2 Reset = 1'b0;
        #1 expect3("rstasync", 10'h000, 1'b0, 1'b0);
        @(posedge BitCLK_10);
        #1 expect3("rsthold", 10'h000, 1'b0, 1'b0);
        mRd = 1'b0;
        rs  = -1;
      end
      v = ($urandom_range(3) != 0);
      k = ($urandom_range(3) == 0);
      if (k && $urandom_range(1) == 1) b = LEGALK[$urandom_range(11)];
      else                             b = 8'($urandom_range(255));
      refEnc(b, k, v, mRd, eSym, eRd, eErr);
      step(b, k, v);
      expect3("rand", eSym, eRd, eErr);
      disp = 2 * $countones(TxParallel_10) - 10;
      chk("rand.disp", 10'(disp == -2 || disp == 0 || disp == 2), 10'd1);
      rs += disp;
      chk("rand.rsum", 10'(rs == 1 || rs == -1), 10'd1);
      chk("rand.rsdir", 10'(RunningDisp), 10'(rs > 0));
      mRd = eRd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- 8b/10b line encoder for the TX path; the transmit counterpart of the RX 8b/10b decoder.
- Takes one byte plus a K flag per BitCLK_10 cycle and produces one registered 10-bit symbol for the serializer.
- Tracks running disparity (RD), substitutes K28.5 idle when no data is valid, and flags illegal control codes.

Parameters:
INIT_RD, 1'b0, running disparity after reset (0 = RD-, 1 = RD+)

Ports:
BitCLK_10  input  1  symbol clock (one symbol per cycle)
Reset  input  1  asynchronous, active-low reset
TxParallel_8  input  8  byte to encode, {HGF, EDCBA}; [4:0] = EDCBA, [7:5] = HGF
TxDataK  input  1  1 = encode TxParallel_8 as a control (K) code
TxDataValid  input  1  1 = byte valid this cycle; 0 = send idle K28.5
TxParallel_10  output  10  symbol {abcdei, fghj}; bit9 = a, bits[3:0] = fghj, bit0 = j
RunningDisp  output  1  RD after the symbol currently on TxParallel_10 (1 = RD+)
CodeErr  output  1  1 = the symbol on TxParallel_10 replaced an illegal K request

Behaviour:
- Single clock domain (BitCLK_10). Reset is asynchronous and active-low.
- Reset values: TxParallel_10 = 10'h000, RunningDisp = INIT_RD, CodeErr = 0.
- Latency: 1 cycle. Inputs sampled at posedge N appear on the outputs after posedge N; no bubbles; a new symbol every cycle.
- Coding tables: IEEE 802.3 Clause 36 5b/6b and 3b/4b. Bit order must match the RX decoder exactly (abcdei in [9:4], fghj in [3:0]).
- 6b sub-block:
  - Selected from EDCBA using the current RD.
  - RD_mid = + if the sub-block has more ones, - if more zeros, unchanged if balanced.
  - D.7 (111000 at RD-, 000111 at RD+) is balanced, so RD is unchanged.
- 4b sub-block:
  - Selected from HGF using RD_mid.
  - Next RD is computed from the 4b sub-block by the same rule.
  - The .x.3 codes (1100 at RD-, 0011 at RD+) are balanced.
- D.x.7 uses the alternate A7 encoding (0111 at RD-, 1000 at RD+) when:
  - RD_mid = - and x ∈ {17, 18, 20}, or
  - RD_mid = + and x ∈ {11, 13, 14}, or
  - TxDataK = 1.
  Otherwise it uses P7 (1110 at RD-, 0001 at RD+).
- Legal K codes: K28.0–K28.7 (8'h1C, 3C, 5C, 7C, 9C, BC, DC, FC), K23.7 (F7), K27.7 (FB), K29.7 (FD), K30.7 (FE).
  - K28.x 6b = 001111 at RD-, 110000 at RD+.
  - K28.1, K28.5 and K28.7 carry the comma.
- Illegal K request (TxDataK = 1, byte not in the legal list):
  - Emit K28.5 at the current RD and update RD normally.
  - CodeErr = 1 for that symbol only.
- TxDataValid = 0: emit K28.5 at the current RD, CodeErr = 0; TxDataK and TxParallel_8 are ignored.
- Both the RD register and RunningDisp update every cycle; RunningDisp equals the RD the next symbol will be encoded against.
- Reset asserted mid-stream: outputs and RD return to their reset values immediately. The first symbol after release is encoded against INIT_RD.
- Every emitted symbol has disparity ∈ {-2, 0, +2}, and the running sum never leaves ±1 (validated by property check).

Decomposition:
- Package enc8b10b_pkg holds:
  - K28_5 byte constant 8'hBC, plus RD-/RD+ symbol constants 10'h0FA and 10'h305.
  - A legal-K lookup function.
  - 5b/6b and 3b/4b table functions returning the RD- encoding plus a "complement at RD+" flag.
- One combinational sub-module, enc_5b6b: EDCBA, K, RD in → abcdei, RD_mid out.
- The 3b/4b selection, A7 rule, idle/error mux and registers stay in the top level.

Test Plan:
- Reset held low → TxParallel_10 = 10'h000, RunningDisp = 0, CodeErr = 0. Release with TxDataValid = 0 → 10'h0FA (RD → 1), then 10'h305 (RD → 0), alternating.
- From RD-, byte 8'h00, K = 0, valid, twice → 10'h274, 10'h274; RunningDisp = 0 after each.
- From RD-: 8'hB5 (D.21.5) → 10'h2AA, RD stays 0. Then 8'hBC, K = 1 → 10'h0FA, RD = 1. Then 8'hBC, K = 1 → 10'h305, RD = 0.
- From RD-, 8'hF1 (D.17.7) → 10'h237 (A7 selected), RunningDisp = 1.
- 8'h00 with K = 1 at RD- → 10'h0FA, CodeErr = 1 for one cycle only. The next valid data symbol has CodeErr = 0.
- 1000-cycle random byte/K/valid stream, including Reset pulses mid-stream. Checks:
  - Loopback through the RX decoder returns the input byte.
  - The running sum stays within ±1.
  - Outputs return to their reset values within the reset assertion.
